// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: takes the ALU result as the effective address, runs one
// request/response bus transaction for legal loads/stores, aligns store lanes,
// extracts and extends load data, and hands a result to write-back.
// Non-memory instructions and faulting accesses skip the bus entirely.
module ysyx_23060203_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        load_q, load_d;
  logic        store_q, store_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  logic        in_is_mem;
  logic        in_f3_legal;
  logic        in_misaligned;
  logic        in_fault;
  logic [31:0] rsp_shifted;
  logic [31:0] load_value;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  // Classify the incoming instruction: illegal funct3 or misalignment faults
  // without touching the bus; funct3[1:0] encodes the access size.
  always_comb begin
    in_is_mem   = in_load | in_store;
    in_f3_legal = 1'b0;
    if (in_load)
      in_f3_legal = in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (in_store)
      in_f3_legal = in_funct3 inside {3'b000, 3'b001, 3'b010};
    in_misaligned = ((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                    ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00));
    in_fault = in_is_mem & (~in_f3_legal | in_misaligned);
  end

  // Load extraction: move the addressed byte/half down to bit 0, then extend.
  always_comb begin
    rsp_shifted = mem_rsp_data >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_value = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_value = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  load_value = {24'd0, rsp_shifted[7:0]};
      3'b101:  load_value = {16'd0, rsp_shifted[15:0]};
      default: load_value = rsp_shifted;
    endcase
  end

  // Store lane replication and byte strobes from the latched size/offset.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        st_wdata = {4{wdata_q[7:0]}};
        st_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata_q[15:0]}};
        st_wstrb = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        st_wdata = wdata_q;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      load_q   <= load_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: one instruction in flight, no accept while in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (in_is_mem && !in_fault) ? REQ : DONE;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: latch on accept, capture the result on the response.
  // Faults and non-memory ops report the latched address as their result.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    load_d   = load_q;
    store_d  = store_q;
    rd_d     = rd_q;
    result_d = result_q;
    err_d    = err_q;
    if (state_q == IDLE && in_valid) begin
      addr_d   = in_addr;
      wdata_d  = in_wdata;
      funct3_d = in_funct3;
      load_d   = in_load;
      store_d  = in_store;
      rd_d     = in_rd;
      result_d = in_addr;
      err_d    = in_fault;
    end else if (state_q == WAIT && mem_rsp_valid) begin
      err_d    = mem_rsp_err;
      result_d = mem_rsp_err ? addr_q : (load_q ? load_value : 32'd0);
    end
  end

  // Outputs: bus signals are driven only in REQ so they read zero when idle.
  always_comb begin
    in_ready      = (state_q == IDLE);
    mem_req_valid = (state_q == REQ);
    mem_addr      = mem_req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wen       = mem_req_valid & store_q;
    mem_wdata     = mem_wen ? st_wdata : 32'd0;
    mem_wstrb     = mem_wen ? st_wstrb : 4'b0000;
    out_valid     = (state_q == DONE);
    out_data      = result_q;
    out_rd        = rd_q;
    out_err       = err_q;
  end

endmodule

// File: doc/ysyx_23060203_lsu.md
# ysyx_23060203_lsu

Load/store unit that sits directly downstream of the execute-stage ALU. It takes the ALU result as the effective address and performs the memory access over a simple request/response bus. It aligns store data and byte strobes, and extracts and sign/zero-extends load data. It returns a result to write-back through a valid/ready handshake. Non-memory instructions pass the ALU result through unchanged, with no bus activity.

## Interface
Parameters:
- none. The address width and data width are fixed at 32.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  LSU can accept; high only in IDLE
- in_addr  in  32  ALU result; effective address for loads/stores, pass-through value otherwise
- in_wdata  in  32  rs2 value for stores
- in_funct3  in  3  RISC-V funct3 of the load/store
- in_load  in  1  instruction is a load
- in_store  in  1  instruction is a store; never high together with in_load
- in_rd  in  5  destination register, passed through
- out_valid  out  1  result available to write-back
- out_ready  in  1  write-back accepts the result
- out_data  out  32  result (see Operation)
- out_rd  out  5  registered in_rd
- out_err  out  1  access fault or misalignment
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wen  out  1  1 = write
- mem_wdata  out  32  lane-aligned store data
- mem_wstrb  out  4  byte enables; 4'b0000 on reads
- mem_rsp_valid  in  1  response valid; always at least one cycle after the request handshake
- mem_rsp_data  in  32  read word
- mem_rsp_err  in  1  bus error on this response

## Operation
- State machine: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, the LSU latches addr, wdata, funct3, load, store and rd.
  - Load/store with legal funct3 and alignment: go to REQ.
  - Anything else: go to DONE.
- REQ: mem_req_valid=1, with mem_addr, mem_wen, mem_wdata and mem_wstrb held stable until mem_req_ready. On handshake, go to WAIT.
- WAIT: wait for mem_rsp_valid. Capture the result, then go to DONE.
- DONE: out_valid=1, with out_data, out_rd and out_err held stable until out_ready. Then go to IDLE. No new input is accepted in the same cycle.
- Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal stores: SB 000, SH 001, SW 010. Any other funct3 sets out_err.
- Misalignment sets out_err and issues no bus request:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- Store lanes:
  - SB: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - SW: wdata unchanged, wstrb=4'b1111.
- Load extract: shift rsp_data right by addr[1:0]*8. Then:
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
  - W: unchanged.
- out_data:
  - Loads: the extracted value.
  - Stores: 0.
  - Non-memory: the latched in_addr.
  - Any error (funct3, misalignment, or mem_rsp_err): the faulting address (latched in_addr, full byte address).
- mem_rsp_err sets out_err for both loads and stores.

## Timing
- Reset, asynchronous: state=IDLE.
  - Outputs go to their idle values: out_valid=0, mem_req_valid=0, out_err=0, out_data=0, out_rd=0, mem_wen=0, mem_wstrb=0, mem_addr=0, mem_wdata=0. in_ready=1 once reset is released.
  - Reset asserted in REQ or WAIT abandons the access. Any later mem_rsp_valid seen in IDLE is ignored.
- Non-memory or error path: accept at T, out_valid at T+1.
- Memory path:
  - Accept at T; mem_req_valid from T+1.
  - Request handshake at cycle H.
  - Earliest response at H+1.
  - out_valid at the cycle after the response.
  - Minimum load/store latency is accept to out_valid = 3 cycles.
- Backpressure:
  - mem_req_ready low: request held indefinitely and unchanged.
  - out_ready low: output held indefinitely and unchanged.
- mem_rsp_valid outside WAIT is ignored.
- Throughput: at most one instruction in flight.

## Test plan
- LB, addr=0x8000_0003, rsp_data=0x80_12_34_56:
  - mem_addr=0x8000_0000, wstrb=0, mem_wen=0.
  - out_data=0xFFFF_FF80, out_err=0, out_valid 3 cycles after accept with zero-wait bus.
- SH, addr=0x0000_0102, wdata=0xDEAD_BEEF:
  - mem_wdata=0xBEEF_BEEF, wstrb=4'b1100, mem_wen=1.
  - out_data=0.
- LW, addr=0x0000_0006:
  - No mem_req_valid.
  - out_err=1, out_data=0x0000_0006, 1 cycle after accept.
- Non-memory, in_addr=0x1234_5678, rd=5:
  - out_data=0x1234_5678, out_rd=5, no bus activity.
- LHU, addr=0x10, mem_req_ready low 4 cycles, response delayed 3 cycles, out_ready low 2 cycles, rsp_data=0x0000_F00D:
  - All request and output signals stable while stalled.
  - in_ready=0 throughout.
  - out_data=0x0000_F00D.
- Reset asserted during WAIT, then a stray mem_rsp_valid:
  - State returns to IDLE, no out_valid.
  - The next LW completes normally.
